// File: rtl/hw_ov7670_tx_pkg.sv
// Shared constants, encodings and the colour-bar table for the OV7670 sensor emulator.
`ifndef HW_OV7670_DWIDTH
`define HW_OV7670_DWIDTH 8
`endif

package hw_ov7670_tx_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_H_BLANK   = 144;
  localparam int DEF_VS_LINES  = 3;
  localparam int DEF_VBP_LINES = 17;
  localparam int DEF_VFP_LINES = 10;
  localparam int DEF_PCLK_DIV  = 2;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_RAMP    = 2'd1,
    MODE_FIXED   = 2'd2,
    MODE_STRIPES = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_e;

  // RGB565 colour bars, left to right
  function automatic logic [15:0] barColour(input logic [2:0] bar);
    case (bar)
      3'd0:    barColour = 16'hFFFF;
      3'd1:    barColour = 16'hFFE0;
      3'd2:    barColour = 16'h07FF;
      3'd3:    barColour = 16'h07E0;
      3'd4:    barColour = 16'hF81F;
      3'd5:    barColour = 16'hF800;
      3'd6:    barColour = 16'h001F;
      default: barColour = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/hw_ov7670_tx_if.sv
// Camera-side parallel bus plus control/status between the emulator and the capture block.
`ifndef HW_OV7670_DWIDTH
`define HW_OV7670_DWIDTH 8
`endif

interface hw_ov7670_tx_if #(
  parameter int DWIDTH = `HW_OV7670_DWIDTH
);
  logic              RST;
  logic              en;
  logic [1:0]        mode;
  logic [15:0]       fixed_rgb;
  logic              PCLK;
  logic              HREF;
  logic              VSYNC;
  logic [DWIDTH-1:0] D;
  logic              busy;
  logic              frame_done;
  logic [15:0]       frame_cnt;

  modport master (
    input  RST, en, mode, fixed_rgb,
    output PCLK, HREF, VSYNC, D, busy, frame_done, frame_cnt
  );

  modport slave (
    output RST, en, mode, fixed_rgb,
    input  PCLK, HREF, VSYNC, D, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/hw_ov7670_tx_pattern.sv
// Combinational test-pattern byte for one position of an active line.
module hw_ov7670_tx_pattern
  import hw_ov7670_tx_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int DWIDTH   = `HW_OV7670_DWIDTH
) (
  input  logic [1:0]        mode_i,
  input  logic [15:0]       byteIdx_i,
  input  logic [7:0]        line_i,
  input  logic [15:0]       fixedRgb_i,
  output logic [DWIDTH-1:0] data_o
);
  localparam int BAR_W = H_ACTIVE / 8;

  logic [15:0] x;
  logic [2:0]  bar;
  logic [15:0] pix;
  logic [7:0]  val;

  assign x   = byteIdx_i >> 1;
  assign bar = 3'(x / 16'(BAR_W));

  // Even byte carries the high half of the RGB565 pixel
  always_comb begin
    pix = fixedRgb_i;
    val = '0;
    case (mode_e'(mode_i))
      MODE_BARS: begin
        pix = barColour(bar);
        val = byteIdx_i[0] ? pix[7:0] : pix[15:8];
      end
      MODE_RAMP:    val = byteIdx_i[7:0];
      MODE_FIXED:   val = byteIdx_i[0] ? pix[7:0] : pix[15:8];
      MODE_STRIPES: val = line_i;
      default:      val = '0;
    endcase
    data_o = DWIDTH'(val);
  end
endmodule

// File: rtl/hw_ov7670_tx.sv
// OV7670 sensor emulator: PCLK divider, frame timing FSM and registered HREF/VSYNC/D.
module hw_ov7670_tx
  import hw_ov7670_tx_pkg::*;
#(
  parameter int DWIDTH    = `HW_OV7670_DWIDTH,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int H_BLANK   = DEF_H_BLANK,
  parameter int VS_LINES  = DEF_VS_LINES,
  parameter int VBP_LINES = DEF_VBP_LINES,
  parameter int VFP_LINES = DEF_VFP_LINES,
  parameter int PCLK_DIV  = DEF_PCLK_DIV
) (
  input logic            aclk,
  input logic            rst,
  hw_ov7670_tx_if.master sensor
);
  localparam int HALF       = PCLK_DIV / 2;
  localparam int LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
  localparam int BW         = $clog2(LINE_BYTES);
  localparam int LW         = $clog2(VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES + 1);
  localparam int CW         = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0]     divCnt_q;
  logic              pclk_q;
  logic              tick;
  state_e            state_q, state_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic [LW-1:0]     line_q, line_d, lastLine;
  logic              frameEnd, frameStart;
  logic [1:0]        mode_q;
  logic [15:0]       fixed_q;
  logic              href_d, vsync_d;
  logic [DWIDTH-1:0] data_d, patData;
  logic              href_q, vsync_q, busy_q, frameDone_q;
  logic [DWIDTH-1:0] data_q;
  logic [15:0]       frameCnt_q;

  // A byte boundary is the aclk cycle in which PCLK falls
  assign tick = pclk_q && (divCnt_q == CW'(HALF - 1));

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      divCnt_q <= '0;
      pclk_q   <= 1'b0;
    end else if (divCnt_q == CW'(HALF - 1)) begin
      divCnt_q <= '0;
      pclk_q   <= ~pclk_q;
    end else begin
      divCnt_q <= divCnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      line_q  <= '0;
      mode_q  <= '0;
      fixed_q <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
      if (frameStart) begin
        mode_q  <= sensor.mode;
        fixed_q <= sensor.fixed_rgb;
      end
    end
  end

  // Counters point at the byte being shown; on a tick they move to the next byte
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    line_d   = line_q;
    frameEnd = 1'b0;
    case (state_q)
      ST_VSYNC:  lastLine = LW'(VS_LINES - 1);
      ST_VBP:    lastLine = LW'(VBP_LINES - 1);
      ST_ACTIVE: lastLine = LW'(V_ACTIVE - 1);
      default:   lastLine = LW'(VFP_LINES - 1);
    endcase
    if (!sensor.RST) begin
      state_d = ST_IDLE;
      byte_d  = '0;
      line_d  = '0;
    end else if (tick) begin
      if (state_q == ST_IDLE) begin
        if (sensor.en) state_d = ST_VSYNC;
      end else if (byte_q != BW'(LINE_BYTES - 1)) begin
        byte_d = byte_q + 1'b1;
      end else begin
        byte_d = '0;
        if (line_q != lastLine) begin
          line_d = line_q + 1'b1;
        end else begin
          line_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBP;
            ST_VBP:    state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFP;
            default: begin
              frameEnd = 1'b1;
              state_d  = sensor.en ? ST_VSYNC : ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign frameStart = (state_d == ST_VSYNC) && ((state_q == ST_IDLE) || frameEnd);

  hw_ov7670_tx_pattern #(
    .H_ACTIVE(H_ACTIVE),
    .DWIDTH  (DWIDTH)
  ) u_pattern (
    .mode_i    (mode_q),
    .byteIdx_i (16'(byte_d)),
    .line_i    (8'(line_d)),
    .fixedRgb_i(fixed_q),
    .data_o    (patData)
  );

  always_comb begin
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE) && (32'(byte_d) < 32'(2 * H_ACTIVE));
    data_d  = href_d ? patData : '0;
  end

  // Sensor reset clears the bus at once; otherwise outputs move only on PCLK falls
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      frameCnt_q  <= '0;
    end else begin
      frameDone_q <= frameEnd;
      if (!sensor.RST) begin
        href_q  <= 1'b0;
        vsync_q <= 1'b0;
        data_q  <= '0;
        busy_q  <= 1'b0;
      end else if (tick) begin
        href_q  <= href_d;
        vsync_q <= vsync_d;
        data_q  <= data_d;
        busy_q  <= (state_d != ST_IDLE);
      end
      if (frameEnd) frameCnt_q <= frameCnt_q + 16'd1;
    end
  end

  assign sensor.PCLK       = pclk_q;
  assign sensor.HREF       = href_q;
  assign sensor.VSYNC      = vsync_q;
  assign sensor.D          = data_q;
  assign sensor.busy       = busy_q;
  assign sensor.frame_done = frameDone_q;
  assign sensor.frame_cnt  = frameCnt_q;
endmodule

// File: tb/tb_hw_ov7670_tx.sv
// Bench for hw_ov7670_tx: frame-position model checked every aclk plus literal pattern checks.
module tb_hw_ov7670_tx;
  localparam int HA  = 8;
  localparam int VA  = 4;
  localparam int HB  = 4;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int VFP = 1;
  localparam int LB  = 2 * HA + HB;
  localparam int FB  = LB * (VS + VBP + VA + VFP);

  logic aclk = 1'b0;
  logic rst  = 1'b1;
  always #5 aclk = ~aclk;

  hw_ov7670_tx_if #(.DWIDTH(8)) sensor ();

  hw_ov7670_tx #(
    .DWIDTH(8), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP), .PCLK_DIV(2)
  ) dut (
    .aclk  (aclk),
    .rst   (rst),
    .sensor(sensor)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] barTable [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0]  barLine [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  // Model: position in bytes from the start of the running frame
  bit          mPclk, mActive, mDone, mHref, mVsync, mBusy;
  int          mPos;
  logic [7:0]  mD;
  logic [15:0] mCnt;
  logic [1:0]  mMode;
  logic [15:0] mFixed;

  logic [7:0] capQ [$];
  int  doneCount = 0;
  int  cyc = 0;
  int  startCyc = 0;
  int  frameLen = 0;
  bit  vsyncAtDone = 0;
  bit  prevPclk = 0;
  bit  prevVsync = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit enV, input bit rstnV, input logic [1:0] modeV,
                               input logic [15:0] fixedV);
    @(posedge aclk);
    #2;
    sensor.en        = enV;
    sensor.RST       = rstnV;
    sensor.mode      = modeV;
    sensor.fixed_rgb = fixedV;
  endtask

  function automatic logic [7:0] modelByte(input logic [1:0] md, input logic [15:0] fx,
                                           input int b, input int y);
    logic [15:0] pix;
    case (md)
      2'd0: begin
        pix = barTable[(b / 2) / (HA / 8)];
        return (b % 2 == 0) ? pix[15:8] : pix[7:0];
      end
      2'd1:    return 8'(b);
      2'd2:    return (b % 2 == 0) ? fx[15:8] : fx[7:0];
      default: return 8'(y);
    endcase
  endfunction

  // Compare against the model, then step the model over the coming posedge
  always @(negedge aclk) begin
    bit tick;
    int line, b;
    cyc++;
    checkOutput("cycle",
      32'({sensor.PCLK, sensor.HREF, sensor.VSYNC, sensor.D, sensor.busy,
           sensor.frame_done, sensor.frame_cnt}),
      32'({mPclk, mHref, mVsync, mD, mBusy, mDone, mCnt}));
    if (sensor.PCLK && !prevPclk && sensor.HREF) capQ.push_back(sensor.D);
    if (sensor.frame_done) begin
      doneCount++;
      frameLen    = cyc - startCyc;
      vsyncAtDone = sensor.VSYNC;
    end
    if (sensor.VSYNC && !prevVsync) startCyc = cyc;
    prevPclk  = sensor.PCLK;
    prevVsync = sensor.VSYNC;

    if (rst) begin
      mPclk = 0; mActive = 0; mDone = 0; mHref = 0; mVsync = 0; mBusy = 0;
      mPos = 0; mD = 0; mCnt = 0;
    end else begin
      tick  = mPclk;
      mPclk = !mPclk;
      mDone = 0;
      if (!sensor.RST) begin
        mActive = 0; mPos = 0; mHref = 0; mVsync = 0; mD = 0; mBusy = 0;
      end else if (tick) begin
        if (!mActive) begin
          if (sensor.en) begin
            mActive = 1; mPos = 0; mMode = sensor.mode; mFixed = sensor.fixed_rgb;
          end
        end else begin
          mPos++;
          if (mPos == FB) begin
            mDone = 1;
            mCnt++;
            if (sensor.en) begin
              mPos = 0; mMode = sensor.mode; mFixed = sensor.fixed_rgb;
            end else begin
              mActive = 0;
            end
          end
        end
        line   = mPos / LB;
        b      = mPos % LB;
        mVsync = mActive && (line < VS);
        mHref  = mActive && (line >= VS + VBP) && (line < VS + VBP + VA) && (b < 2 * HA);
        mD     = mHref ? modelByte(mMode, mFixed, b, line - VS - VBP) : 8'h00;
        mBusy  = mActive;
      end
    end
  end

  task automatic waitBusy(input string name);
    int n = 0;
    while (!sensor.busy && n < 20) begin @(posedge aclk); #2; n++; end
    checkOutput(name, 32'(sensor.busy), 32'd1);
  endtask

  task automatic waitFrameDone(input string name);
    int start = doneCount;
    int n = 0;
    while (doneCount == start && n < 600) begin @(posedge aclk); #2; n++; end
    checkOutput(name, 32'(doneCount - start), 32'd1);
  endtask

  task automatic runFrame(input logic [1:0] md, input logic [15:0] fx, input string name);
    capQ.delete();
    applyStimulus(1, 1, md, fx);
    waitBusy({name, "Busy"});
    applyStimulus(0, 1, md, fx);
    waitFrameDone({name, "Done"});
  endtask

  task automatic checkByte(input string name, input int idx, input logic [7:0] exp);
    if (idx < capQ.size()) checkOutput(name, 32'(capQ[idx]), 32'(exp));
    else checkOutput(name, 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    int preAbort;
    sensor.RST = 1; sensor.en = 0; sensor.mode = 0; sensor.fixed_rgb = 0;
    repeat (3) @(posedge aclk);
    #2;
    checkOutput("resetPclk", 32'(sensor.PCLK), 32'd0);
    checkOutput("resetCnt", 32'(sensor.frame_cnt), 32'd0);
    rst = 0;
    @(posedge aclk); #2;
    checkOutput("pclkHigh", 32'(sensor.PCLK), 32'd1);
    @(posedge aclk); #2;
    checkOutput("pclkLow", 32'(sensor.PCLK), 32'd0);
    repeat (10) @(posedge aclk);
    #2;
    checkOutput("idleBus", 32'({sensor.HREF, sensor.VSYNC, sensor.D, sensor.busy}), 32'd0);

    runFrame(2'd0, 16'h0000, "bars");
    checkOutput("barsLen", 32'(frameLen), 32'd280);
    checkOutput("barsCnt", 32'(sensor.frame_cnt), 32'd1);
    checkOutput("barsBytes", 32'(capQ.size()), 32'd64);
    checkOutput("barsVsyncAtDone", 32'(vsyncAtDone), 32'd0);
    for (int i = 0; i < 64; i++) checkByte($sformatf("barsByte%0d", i), i, barLine[i % 16]);
    repeat (4) @(posedge aclk);
    #2;
    checkOutput("barsIdleBusy", 32'(sensor.busy), 32'd0);

    runFrame(2'd2, 16'hABCD, "fixed");
    checkByte("fixed0", 0, 8'hAB);
    checkByte("fixed1", 1, 8'hCD);
    checkByte("fixed63", 63, 8'hCD);
    checkOutput("fixedCnt", 32'(sensor.frame_cnt), 32'd2);

    runFrame(2'd1, 16'h0000, "ramp");
    for (int i = 0; i < 16; i++) checkByte($sformatf("ramp%0d", i), i, 8'(i));
    checkByte("ramp16", 16, 8'h00);
    checkOutput("rampCnt", 32'(sensor.frame_cnt), 32'd3);

    runFrame(2'd3, 16'h0000, "stripes");
    checkByte("stripe0", 0, 8'h00);
    checkByte("stripe16", 16, 8'h01);
    checkByte("stripe32", 32, 8'h02);
    checkByte("stripe63", 63, 8'h03);
    checkOutput("stripesCnt", 32'(sensor.frame_cnt), 32'd4);

    // Back-to-back frames, mode changed mid-frame 1 only takes effect in frame 2
    capQ.delete();
    applyStimulus(1, 1, 2'd0, 16'h0000);
    waitBusy("b2bBusy");
    repeat (20) @(posedge aclk);
    applyStimulus(1, 1, 2'd3, 16'h0000);
    waitFrameDone("b2bDone1");
    checkByte("b2bBars3", 3, 8'hE0);
    checkByte("b2bBars8", 8, 8'hF8);
    checkOutput("b2bVsync1", 32'(vsyncAtDone), 32'd1);
    checkOutput("b2bLen1", 32'(frameLen), 32'd280);
    capQ.delete();
    waitFrameDone("b2bDone2");
    checkByte("b2bStripe16", 16, 8'h01);
    checkByte("b2bStripe63", 63, 8'h03);
    checkOutput("b2bVsync2", 32'(vsyncAtDone), 32'd1);
    checkOutput("b2bLen2", 32'(frameLen), 32'd280);
    repeat (50) @(posedge aclk);
    applyStimulus(0, 1, 2'd3, 16'h0000);
    waitFrameDone("b2bDone3");
    checkOutput("b2bVsync3", 32'(vsyncAtDone), 32'd0);
    checkOutput("b2bCnt", 32'(sensor.frame_cnt), 32'd7);
    repeat (4) @(posedge aclk);
    #2;
    checkOutput("b2bIdle", 32'(sensor.busy), 32'd0);

    // Abort in the middle of an active line
    applyStimulus(1, 1, 2'd0, 16'h0000);
    begin
      int n = 0;
      while (!sensor.HREF && n < 600) begin @(posedge aclk); #2; n++; end
    end
    checkOutput("abortHrefSeen", 32'(sensor.HREF), 32'd1);
    preAbort = doneCount;
    applyStimulus(1, 0, 2'd0, 16'h0000);
    @(posedge aclk); #2;
    checkOutput("abortBus", 32'({sensor.HREF, sensor.D, sensor.busy}), 32'd0);
    applyStimulus(0, 0, 2'd0, 16'h0000);
    repeat (300) @(posedge aclk);
    #2;
    checkOutput("abortNoDone", 32'(doneCount), 32'(preAbort));
    checkOutput("abortCnt", 32'(sensor.frame_cnt), 32'd7);
    applyStimulus(0, 1, 2'd0, 16'h0000);
    repeat (10) @(posedge aclk);
    #2;
    checkOutput("finalIdle", 32'({sensor.VSYNC, sensor.busy}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
